// File: rtl/pixel_packer_if.sv
// Pixel input and AXI4-Stream output bundle for pixel_packer.
// master: the packer's view (consumes pixels, drives the stream). slave: the environment's view.
interface pixel_packer_if;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        valid;
    logic        sof;
    logic        eol;
    logic        in_stream_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;

    modport master (
        input  r, g, b, valid, sof, eol, out_stream_tready,
        output in_stream_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid
    );

    modport slave (
        output r, g, b, valid, sof, eol, out_stream_tready,
        input  in_stream_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid
    );
endinterface

// File: rtl/pixel_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words); PIXEL_PACKER_EOL_FLUSH_EN adds eol flush.
// Latency: one cycle from the accepting edge to tvalid.
// Backpressure: ready only while the output register is free; held low while a flush remainder is queued.
module pixel_packer (
    input  logic           aclk,
    input  logic           aresetn,
    pixel_packer_if.master pp
);
    logic [1:0]  phase;
    logic [1:0]  cur_phase;
    logic [1:0]  phase_nxt;
    logic [23:0] byte_buf;
    logic [23:0] buf_nxt;
    logic        tuser_pend;
    logic        flush_pending;
    logic        flush_load;
    logic [3:0]  flush_keep;
    logic        out_free;
    logic        accept;
    logic        eol_flush;
    logic        emit;
    logic        emit_last;
    logic [31:0] emit_dat;
    logic [3:0]  emit_keep;

    logic        tvalid_q;
    logic        tlast_q;
    logic        tuser_q;
    logic [31:0] tdata_q;
    logic [3:0]  tkeep_q;

    assign out_free           = !tvalid_q || pp.out_stream_tready;
    assign pp.in_stream_ready = out_free && !flush_pending && aresetn;
    assign accept             = pp.valid && pp.in_stream_ready;
    // sof restarts the group: leftover bytes are simply never read again
    assign cur_phase          = pp.sof ? 2'd0 : phase;
    assign flush_load         = flush_pending && out_free;

`ifdef PIXEL_PACKER_EOL_FLUSH_EN
    assign eol_flush = pp.eol && (cur_phase != 2'd3);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            flush_pending <= 1'b0;
            flush_keep    <= 4'hF;
        end else if (accept && eol_flush && (cur_phase != 2'd0)) begin
            flush_pending <= 1'b1;
            flush_keep    <= (cur_phase == 2'd1) ? 4'h3 : 4'h1;
        end else if (flush_load) begin
            flush_pending <= 1'b0;
        end
    end
`else
    assign eol_flush     = 1'b0;
    assign flush_pending = 1'b0;
    assign flush_keep    = 4'hF;
`endif

    // Leftover bytes sit right-aligned in byte_buf, so upper bytes are zero for the flush word
    always_comb begin
        emit      = 1'b1;
        emit_dat  = '0;
        emit_keep = 4'hF;
        emit_last = 1'b0;
        buf_nxt   = '0;
        phase_nxt = eol_flush ? 2'd0 : cur_phase + 2'd1;
        case (cur_phase)
            2'd0: begin
                if (eol_flush) begin
                    emit_dat  = {8'h00, pp.b, pp.g, pp.r};
                    emit_keep = 4'h7;
                    emit_last = 1'b1;
                end else begin
                    emit    = 1'b0;
                    buf_nxt = {pp.b, pp.g, pp.r};
                end
            end
            2'd1: begin
                emit_dat = {pp.r, byte_buf};
                buf_nxt  = {8'h00, pp.b, pp.g};
            end
            2'd2: begin
                emit_dat = {pp.g, pp.r, byte_buf[15:0]};
                buf_nxt  = {16'h0000, pp.b};
            end
            default: begin
                emit_dat  = {pp.b, pp.g, pp.r, byte_buf[7:0]};
                emit_last = pp.eol;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase      <= 2'd0;
            byte_buf   <= '0;
            tuser_pend <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
        end else begin
            if (accept) begin
                phase      <= phase_nxt;
                byte_buf   <= buf_nxt;
                tuser_pend <= emit ? 1'b0 : (tuser_pend || pp.sof);
            end else if (flush_load) begin
                byte_buf   <= '0;
                tuser_pend <= 1'b0;
            end

            if (accept && emit) begin
                tvalid_q <= 1'b1;
                tdata_q  <= emit_dat;
                tkeep_q  <= emit_keep;
                tlast_q  <= emit_last;
                tuser_q  <= tuser_pend || pp.sof;
            end else if (flush_load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= {8'h00, byte_buf};
                tkeep_q  <= flush_keep;
                tlast_q  <= 1'b1;
                tuser_q  <= tuser_pend;
            end else if (pp.out_stream_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign pp.out_stream_tvalid = tvalid_q;
    assign pp.out_stream_tdata  = tdata_q;
    assign pp.out_stream_tkeep  = tkeep_q;
    assign pp.out_stream_tlast  = tlast_q;
    assign pp.out_stream_tuser  = tuser_q;
endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer: vector table plus hand sequences for stall, line, reset and eol cases.
module tb_pixel_packer;
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    pixel_packer_if pif();

    pixel_packer dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .pp      (pif)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        vld;
        logic        sof;
        logic        eol;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        exp_vld;
        logic [31:0] exp_dat;
        logic        exp_user;
        logic        exp_last;
    } vec_t;

    vec_t        vecs [12];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wcnt;
    logic [31:0] exp_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_pix(input logic v, input logic s, input logic e,
                           input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        pif.valid = v;
        pif.sof   = s;
        pif.eol   = e;
        pif.r     = rr;
        pif.g     = gg;
        pif.b     = bb;
    endtask

    task automatic chk_word(input string nm, input logic [31:0] dat, input logic [3:0] keep,
                            input logic user, input logic last);
        chk({nm, "_vld"},  32'(pif.out_stream_tvalid), 32'd1);
        chk({nm, "_dat"},  pif.out_stream_tdata, dat);
        chk({nm, "_keep"}, 32'(pif.out_stream_tkeep), 32'(keep));
        chk({nm, "_user"}, 32'(pif.out_stream_tuser), 32'(user));
        chk({nm, "_last"}, 32'(pif.out_stream_tlast), 32'(last));
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_tvalid"}, 32'(pif.out_stream_tvalid), 32'd0);
        chk({nm, "_tdata"},  pif.out_stream_tdata, 32'd0);
        chk({nm, "_tkeep"},  32'(pif.out_stream_tkeep), 32'd0);
        chk({nm, "_tlast"},  32'(pif.out_stream_tlast), 32'd0);
        chk({nm, "_tuser"},  32'(pif.out_stream_tuser), 32'd0);
        chk({nm, "_ready"},  32'(pif.in_stream_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          vld sof eol  r      g      b    exp_vld exp_dat      user last
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h04, 8'h05, 8'h06, 1'b1, 32'h04030201, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h07, 8'h08, 8'h09, 1'b1, 32'h08070605, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h0A, 8'h0B, 8'h0C, 1'b1, 32'h0C0B0A09, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h12, 8'h13, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'hEE, 8'hEE, 8'hEE, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h14, 8'h15, 8'h16, 1'b1, 32'h14131211, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h17, 8'h18, 8'h19, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h21, 8'h22, 8'h23, 1'b1, 32'h21191817, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h24, 8'h25, 8'h26, 1'b1, 32'h25242322, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h27, 8'h28, 8'h29, 1'b1, 32'h29282726, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 32'h0,        1'b0, 1'b0};

        set_pix(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        pif.out_stream_tready = 1'b1;

        // Reset state
        #12;
        chk_zero_outputs("reset");
        #10;
        aresetn = 1'b1;

        // Table: basic packing, sof at phase 0 and mid-group, ignored invalid, eol at phase 3
        for (int i = 0; i < 12; i++) begin
            set_pix(vecs[i].vld, vecs[i].sof, vecs[i].eol, vecs[i].r, vecs[i].g, vecs[i].b);
            cyc();
            chk($sformatf("vec%0d_vld", i), 32'(pif.out_stream_tvalid), 32'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) begin
                chk($sformatf("vec%0d_dat", i),  pif.out_stream_tdata, vecs[i].exp_dat);
                chk($sformatf("vec%0d_user", i), 32'(pif.out_stream_tuser), 32'(vecs[i].exp_user));
                chk($sformatf("vec%0d_last", i), 32'(pif.out_stream_tlast), 32'(vecs[i].exp_last));
                chk($sformatf("vec%0d_keep", i), 32'(pif.out_stream_tkeep), 32'hF);
            end
            chk($sformatf("vec%0d_ready", i), 32'(pif.in_stream_ready), 32'd1);
        end

        // 640-pixel line, byte stream counts 0,1,2,... so word w is bytes 4w..4w+3
        wcnt = 0;
        for (int i = 0; i < 644; i++) begin
            if (i < 640)
                set_pix(1'b1, 1'b0, (i == 639), 8'(3 * i), 8'(3 * i + 1), 8'(3 * i + 2));
            else
                set_pix(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            cyc();
            if (pif.out_stream_tvalid) begin
                exp_w = {8'(4 * wcnt + 3), 8'(4 * wcnt + 2), 8'(4 * wcnt + 1), 8'(4 * wcnt)};
                chk("line_dat",  pif.out_stream_tdata, exp_w);
                chk("line_last", 32'(pif.out_stream_tlast), 32'(wcnt == 479));
                wcnt++;
            end
        end
        chk("line_words", 32'(wcnt), 32'd480);

        // Output stall: word held, input blocked, nothing lost or duplicated
        set_pix(1'b1, 1'b0, 1'b0, 8'h41, 8'h42, 8'h43);
        cyc();
        set_pix(1'b1, 1'b0, 1'b0, 8'h44, 8'h45, 8'h46);
        cyc();
        chk_word("stall_w0", 32'h44434241, 4'hF, 1'b0, 1'b0);
        pif.out_stream_tready = 1'b0;
        set_pix(1'b1, 1'b0, 1'b0, 8'h47, 8'h48, 8'h49);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("stall%0d_vld", k),   32'(pif.out_stream_tvalid), 32'd1);
            chk($sformatf("stall%0d_dat", k),   pif.out_stream_tdata, 32'h44434241);
            chk($sformatf("stall%0d_ready", k), 32'(pif.in_stream_ready), 32'd0);
        end
        pif.out_stream_tready = 1'b1;
        cyc();
        chk_word("stall_w1", 32'h48474645, 4'hF, 1'b0, 1'b0);
        set_pix(1'b1, 1'b0, 1'b0, 8'h4A, 8'h4B, 8'h4C);
        cyc();
        chk_word("stall_w2", 32'h4C4B4A49, 4'hF, 1'b0, 1'b0);
        set_pix(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        cyc();
        chk("stall_idle", 32'(pif.out_stream_tvalid), 32'd0);

        // Reset mid-group with a word waiting and a byte left over
        set_pix(1'b1, 1'b1, 1'b0, 8'h51, 8'h52, 8'h53);
        cyc();
        set_pix(1'b1, 1'b0, 1'b0, 8'h54, 8'h55, 8'h56);
        cyc();
        chk_word("rst_pre0", 32'h54535251, 4'hF, 1'b1, 1'b0);
        set_pix(1'b1, 1'b0, 1'b0, 8'h57, 8'h58, 8'h59);
        cyc();
        chk_word("rst_pre1", 32'h58575655, 4'hF, 1'b0, 1'b0);
        pif.out_stream_tready = 1'b0;
        set_pix(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        #2;
        aresetn = 1'b0;
        #1;
        chk_zero_outputs("rst_mid");
        aresetn = 1'b1;
        pif.out_stream_tready = 1'b1;
        set_pix(1'b1, 1'b0, 1'b0, 8'h61, 8'h62, 8'h63);
        cyc();
        chk("rst_post_p0", 32'(pif.out_stream_tvalid), 32'd0);
        set_pix(1'b1, 1'b0, 1'b0, 8'h64, 8'h65, 8'h66);
        cyc();
        chk_word("rst_post_w0", 32'h64636261, 4'hF, 1'b0, 1'b0);
        set_pix(1'b1, 1'b0, 1'b0, 8'h67, 8'h68, 8'h69);
        cyc();
        chk_word("rst_post_w1", 32'h68676665, 4'hF, 1'b0, 1'b0);
        set_pix(1'b1, 1'b0, 1'b0, 8'h6A, 8'h6B, 8'h6C);
        cyc();
        chk_word("rst_post_w2", 32'h6C6B6A69, 4'hF, 1'b0, 1'b0);
        set_pix(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        cyc();

        // eol before the group is complete
`ifdef PIXEL_PACKER_EOL_FLUSH_EN
        set_pix(1'b1, 1'b0, 1'b1, 8'hAA, 8'hBB, 8'hCC);
        cyc();
        chk_word("flush_p0", 32'h00CCBBAA, 4'h7, 1'b0, 1'b1);
        set_pix(1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 8'h03);
        cyc();
        chk("flush_p1_gap", 32'(pif.out_stream_tvalid), 32'd0);
        set_pix(1'b1, 1'b0, 1'b1, 8'h04, 8'h05, 8'h06);
        cyc();
        chk_word("flush_p1_full", 32'h04030201, 4'hF, 1'b0, 1'b0);
        chk("flush_p1_ready", 32'(pif.in_stream_ready), 32'd0);
        set_pix(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        cyc();
        chk_word("flush_p1_rem", 32'h00000605, 4'h3, 1'b0, 1'b1);
        cyc();
        chk("flush_done_vld", 32'(pif.out_stream_tvalid), 32'd0);
        chk("flush_done_ready", 32'(pif.in_stream_ready), 32'd1);
`else
        set_pix(1'b1, 1'b0, 1'b1, 8'hAA, 8'hBB, 8'hCC);
        cyc();
        chk("noflush_p0", 32'(pif.out_stream_tvalid), 32'd0);
        set_pix(1'b1, 1'b0, 1'b0, 8'hDD, 8'hEE, 8'hFF);
        cyc();
        chk_word("noflush_w0", 32'hDDCCBBAA, 4'hF, 1'b0, 1'b0);
        set_pix(1'b1, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33);
        cyc();
        chk_word("noflush_w1", 32'h2211FFEE, 4'hF, 1'b0, 1'b0);
        set_pix(1'b1, 1'b0, 1'b1, 8'h44, 8'h55, 8'h66);
        cyc();
        chk_word("noflush_w2", 32'h66554433, 4'hF, 1'b0, 1'b1);
        set_pix(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        cyc();
        chk("noflush_idle", 32'(pif.out_stream_tvalid), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
